apb_master_ctrl: RTL and testbench

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

---
 rtl/apb_master_ctrl_if.sv | 41 ++++
 rtl/apb_master_ctrl.sv | 154 +++++++++++++++
 tb/tb_apb_master_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/apb_master_ctrl_if.sv
// apb_master_ctrl_if
//   Bundles the AHB-side handshake and the APB-side bus signals of the
//   AHB-to-APB bridge controller.
//   AHB side : valid, Hwrite, Haddr, Hwdata, tempselx -> controller
//              Hreadyout, Hresp, Hrdata             <- controller
//   APB side : Prdata, Pready, Pslverr              -> controller
//              Pselx, Penable, Pwrite, Paddr, Pwdata <- controller
//   modport master : the controller's view
//   modport slave  : the environment's view (AHB master + APB slaves)
interface apb_master_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
);
    logic              valid;
    logic              Hwrite;
    logic [ADDR_W-1:0] Haddr;
    logic [DATA_W-1:0] Hwdata;
    logic [NSLV-1:0]   tempselx;
    logic [DATA_W-1:0] Prdata;
    logic              Pready;
    logic              Pslverr;
    logic              Hreadyout;
    logic              Hresp;
    logic [DATA_W-1:0] Hrdata;
    logic [NSLV-1:0]   Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;

    modport master (
        input  valid, Hwrite, Haddr, Hwdata, tempselx, Prdata, Pready, Pslverr,
        output Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
    );

    modport slave (
        output valid, Hwrite, Haddr, Hwdata, tempselx, Prdata, Pready, Pslverr,
        input  Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl
//   AHB-to-APB bridge controller. Accepts one AHB transfer at a time, runs
//   the APB SETUP/ACCESS sequence towards the selected slave and returns the
//   result (read data or a two-cycle AHB ERROR response).
//   Ports:
//     Hclk    : sole clock, rising edge
//     Hresetn : asynchronous active-low reset
//     bus     : apb_master_ctrl_if.master (AHB handshake + APB bus)
//   Every output is either a flop or a decode of the state register and
//   latched fields, so there is no input-to-output combinational path.
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                Hclk,
    input  logic                Hresetn,
    apb_master_ctrl_if.master   bus
);

    localparam int               CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W:0]   TO_LIM = (CNT_W + 1)'(TIMEOUT);
    localparam logic             TO_EN  = (TIMEOUT > 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WWAIT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [NSLV-1:0]     sel_r;
    logic [ADDR_W-1:0]   paddr_r;
    logic [DATA_W-1:0]   pwdata_r;
    logic [DATA_W-1:0]   hrdata_r;
    logic                pwrite_r;
    logic                err_pend_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W:0]      cnt_inc_s;
    logic                to_hit_s;
    logic                sel_ok_s;

    // A decode with more than one bit set is treated like an unmapped address
    // so that Pselx can never be multi-hot.
    assign sel_ok_s  = (bus.tempselx != {NSLV{1'b0}}) &&
                       ((bus.tempselx & (bus.tempselx - NSLV'(1))) == {NSLV{1'b0}});
    assign cnt_inc_s = {1'b0, cnt_r} + (CNT_W + 1)'(1);
    assign to_hit_s  = TO_EN && (cnt_inc_s == TO_LIM);

    // State register.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.valid) begin
                    if (bus.Hwrite) begin
                        state_s = ST_WWAIT;
                    end else if (sel_ok_s) begin
                        state_s = ST_SETUP;
                    end else begin
                        state_s = ST_ERR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WWAIT: begin
                if (sel_r == {NSLV{1'b0}}) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Pslverr only qualifies a cycle where Pready is high.
                if (bus.Pready) begin
                    if (bus.Pslverr) begin
                        state_s = ST_ERR;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (to_hit_s) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_ERR: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Address/control/data latches, wait counter and error-tail flag.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            sel_r      <= {NSLV{1'b0}};
            paddr_r    <= {ADDR_W{1'b0}};
            pwdata_r   <= {DATA_W{1'b0}};
            hrdata_r   <= {DATA_W{1'b0}};
            pwrite_r   <= 1'b0;
            err_pend_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            // Second cycle of the AHB error response is the IDLE after ERR.
            err_pend_r <= (state_r == ST_ERR);
            if ((state_r == ST_IDLE) && bus.valid) begin
                paddr_r  <= bus.Haddr;
                pwrite_r <= bus.Hwrite;
                sel_r    <= sel_ok_s ? bus.tempselx : {NSLV{1'b0}};
            end
            if (state_r == ST_WWAIT) begin
                pwdata_r <= bus.Hwdata;
            end
            if ((state_r == ST_ACCESS) && bus.Pready && !bus.Pslverr && !pwrite_r) begin
                hrdata_r <= bus.Prdata;
            end
            if (state_r == ST_SETUP) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == ST_ACCESS) && !bus.Pready) begin
                cnt_r <= cnt_inc_s[CNT_W-1:0];
            end
        end
    end

    assign bus.Pselx     = ((state_r == ST_SETUP) || (state_r == ST_ACCESS)) ? sel_r : {NSLV{1'b0}};
    assign bus.Penable   = (state_r == ST_ACCESS);
    assign bus.Hreadyout = (state_r == ST_IDLE);
    assign bus.Hresp     = (state_r == ST_ERR) || ((state_r == ST_IDLE) && err_pend_r);
    assign bus.Hrdata    = hrdata_r;
    assign bus.Pwrite    = pwrite_r;
    assign bus.Paddr     = paddr_r;
    assign bus.Pwdata    = pwdata_r;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl
//   Cycle-table bench for apb_master_ctrl (TIMEOUT=4). Each row holds the
//   inputs driven during one clock cycle and the outputs expected in that
//   same cycle; rows are applied one per clock. A hand-written sequence then
//   covers asynchronous reset in ACCESS and acceptance right after release.
module tb_apb_master_ctrl;

    logic Hclk;
    logic Hresetn;

    apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) bus ();

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .NSLV(3), .TIMEOUT(4)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus.master)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct {
        logic        valid;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  tsel;
        logic [31:0] prdata;
        logic        prdy;
        logic        perr;
        logic        e_rdy;
        logic        e_resp;
        logic [2:0]  e_sel;
        logic        e_en;
        logic        e_pw;
        logic [31:0] e_rd;
        logic [31:0] e_pa;
        logic [31:0] e_pwd;
    } vec_t;

    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] W1 = 32'h1234_5678;
    localparam logic [31:0] AA = 32'hAAAA_5555;
    localparam logic [31:0] BD = 32'h0BAD_F00D;
    localparam logic [31:0] RB = 32'h1357_9BDF;
    localparam logic [31:0] CF = 32'hCAFE_0000;
    localparam logic [31:0] Z  = 32'h0000_0000;

    vec_t vecs[34];
    int   errors;
    int   checks;

    function automatic vec_t mk(
        input logic v, input logic w, input logic [31:0] a, input logic [31:0] wd,
        input logic [2:0] ts, input logic [31:0] pr, input logic rdy, input logic err,
        input logic erdy, input logic eresp, input logic [2:0] esel, input logic een,
        input logic epw, input logic [31:0] erd, input logic [31:0] epa, input logic [31:0] epwd);
        vec_t r;
        r.valid = v;    r.wr = w;        r.addr = a;     r.wdata = wd;
        r.tsel = ts;    r.prdata = pr;   r.prdy = rdy;   r.perr = err;
        r.e_rdy = erdy; r.e_resp = eresp; r.e_sel = esel; r.e_en = een;
        r.e_pw = epw;   r.e_rd = erd;    r.e_pa = epa;   r.e_pwd = epwd;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s row=%0d got=%h exp=%h", name, row, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] ts, input logic [31:0] pr, input logic rdy, input logic err);
        bus.valid = v;  bus.Hwrite = w;   bus.Haddr = a;   bus.Hwdata = wd;
        bus.tempselx = ts; bus.Prdata = pr; bus.Pready = rdy; bus.Pslverr = err;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        Hresetn = 1'b0;
        drive(1'b0, 1'b0, Z, Z, 3'b000, Z, 1'b0, 1'b0);

        // read, zero-wait slave
        vecs[0]  = mk(1'b1,1'b0,32'h40,Z,3'b010,DB,1'b1,1'b0, 1'b1,1'b0,3'b000,1'b0,1'b0,Z,Z,Z);
        vecs[1]  = mk(1'b0,1'b0,32'h40,Z,3'b010,DB,1'b1,1'b0, 1'b0,1'b0,3'b010,1'b0,1'b0,Z,32'h40,Z);
        vecs[2]  = mk(1'b0,1'b0,32'h40,Z,3'b010,DB,1'b1,1'b0, 1'b0,1'b0,3'b010,1'b1,1'b0,Z,32'h40,Z);
        // write, three wait states
        vecs[3]  = mk(1'b1,1'b1,32'h10,W1,3'b001,Z,1'b0,1'b0, 1'b1,1'b0,3'b000,1'b0,1'b0,DB,32'h40,Z);
        vecs[4]  = mk(1'b0,1'b1,32'h10,W1,3'b001,Z,1'b0,1'b0, 1'b0,1'b0,3'b000,1'b0,1'b1,DB,32'h10,Z);
        vecs[5]  = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b0, 1'b0,1'b0,3'b001,1'b0,1'b1,DB,32'h10,W1);
        vecs[6]  = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b0, 1'b0,1'b0,3'b001,1'b1,1'b1,DB,32'h10,W1);
        vecs[7]  = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b0, 1'b0,1'b0,3'b001,1'b1,1'b1,DB,32'h10,W1);
        vecs[8]  = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b0, 1'b0,1'b0,3'b001,1'b1,1'b1,DB,32'h10,W1);
        vecs[9]  = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b1,1'b0, 1'b0,1'b0,3'b001,1'b1,1'b1,DB,32'h10,W1);
        // read with slave error
        vecs[10] = mk(1'b1,1'b0,32'h20,Z,3'b100,CF,1'b1,1'b1, 1'b1,1'b0,3'b000,1'b0,1'b1,DB,32'h10,W1);
        vecs[11] = mk(1'b0,1'b0,32'h20,Z,3'b100,CF,1'b1,1'b1, 1'b0,1'b0,3'b100,1'b0,1'b0,DB,32'h20,W1);
        vecs[12] = mk(1'b0,1'b0,32'h20,Z,3'b100,CF,1'b1,1'b1, 1'b0,1'b0,3'b100,1'b1,1'b0,DB,32'h20,W1);
        vecs[13] = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b0, 1'b0,1'b1,3'b000,1'b0,1'b0,DB,32'h20,W1);
        // timeout: Pready held low
        vecs[14] = mk(1'b1,1'b0,32'h30,Z,3'b010,Z,1'b0,1'b0, 1'b1,1'b1,3'b000,1'b0,1'b0,DB,32'h20,W1);
        vecs[15] = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b0, 1'b0,1'b0,3'b010,1'b0,1'b0,DB,32'h30,W1);
        vecs[16] = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b1, 1'b0,1'b0,3'b010,1'b1,1'b0,DB,32'h30,W1);
        vecs[17] = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b0, 1'b0,1'b0,3'b010,1'b1,1'b0,DB,32'h30,W1);
        vecs[18] = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b1, 1'b0,1'b0,3'b010,1'b1,1'b0,DB,32'h30,W1);
        vecs[19] = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b0, 1'b0,1'b0,3'b010,1'b1,1'b0,DB,32'h30,W1);
        vecs[20] = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b0, 1'b0,1'b1,3'b000,1'b0,1'b0,DB,32'h30,W1);
        // unmapped read, then unmapped write
        vecs[21] = mk(1'b1,1'b0,32'h50,Z,3'b000,Z,1'b0,1'b0, 1'b1,1'b1,3'b000,1'b0,1'b0,DB,32'h30,W1);
        vecs[22] = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b0, 1'b0,1'b1,3'b000,1'b0,1'b0,DB,32'h50,W1);
        vecs[23] = mk(1'b1,1'b1,32'h60,AA,3'b000,Z,1'b0,1'b0, 1'b1,1'b1,3'b000,1'b0,1'b0,DB,32'h50,W1);
        vecs[24] = mk(1'b0,1'b0,Z,AA,3'b000,Z,1'b0,1'b0, 1'b0,1'b0,3'b000,1'b0,1'b1,DB,32'h60,W1);
        vecs[25] = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b0, 1'b0,1'b1,3'b000,1'b0,1'b1,DB,32'h60,AA);
        // back-to-back write then read, launched at IDLE sample points
        vecs[26] = mk(1'b1,1'b1,32'h70,BD,3'b001,Z,1'b1,1'b0, 1'b1,1'b1,3'b000,1'b0,1'b1,DB,32'h60,AA);
        vecs[27] = mk(1'b0,1'b0,Z,BD,3'b000,Z,1'b1,1'b0, 1'b0,1'b0,3'b000,1'b0,1'b1,DB,32'h70,AA);
        vecs[28] = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b1,1'b0, 1'b0,1'b0,3'b001,1'b0,1'b1,DB,32'h70,BD);
        vecs[29] = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b1,1'b0, 1'b0,1'b0,3'b001,1'b1,1'b1,DB,32'h70,BD);
        vecs[30] = mk(1'b1,1'b0,32'h74,Z,3'b001,RB,1'b1,1'b0, 1'b1,1'b0,3'b000,1'b0,1'b1,DB,32'h70,BD);
        vecs[31] = mk(1'b0,1'b0,Z,Z,3'b000,RB,1'b1,1'b0, 1'b0,1'b0,3'b001,1'b0,1'b0,DB,32'h74,BD);
        vecs[32] = mk(1'b0,1'b0,Z,Z,3'b000,RB,1'b1,1'b0, 1'b0,1'b0,3'b001,1'b1,1'b0,DB,32'h74,BD);
        vecs[33] = mk(1'b0,1'b0,Z,Z,3'b000,Z,1'b0,1'b0, 1'b1,1'b0,3'b000,1'b0,1'b0,RB,32'h74,BD);

        // reset state while Hresetn is low
        step();
        step();
        chk("rst_hreadyout", -1, {31'd0, bus.Hreadyout}, 32'd1);
        chk("rst_hresp",     -1, {31'd0, bus.Hresp},     32'd0);
        chk("rst_pselx",     -1, {29'd0, bus.Pselx},     32'd0);
        chk("rst_penable",   -1, {31'd0, bus.Penable},   32'd0);
        chk("rst_pwrite",    -1, {31'd0, bus.Pwrite},    32'd0);
        chk("rst_paddr",     -1, bus.Paddr,              32'd0);
        chk("rst_pwdata",    -1, bus.Pwdata,             32'd0);
        chk("rst_hrdata",    -1, bus.Hrdata,             32'd0);

        // release reset; row 0 is sampled on the first edge with Hresetn=1
        Hresetn = 1'b1;
        for (int i = 0; i < 34; i++) begin
            chk("hreadyout", i, {31'd0, bus.Hreadyout}, {31'd0, vecs[i].e_rdy});
            chk("hresp",     i, {31'd0, bus.Hresp},     {31'd0, vecs[i].e_resp});
            chk("pselx",     i, {29'd0, bus.Pselx},     {29'd0, vecs[i].e_sel});
            chk("penable",   i, {31'd0, bus.Penable},   {31'd0, vecs[i].e_en});
            chk("pwrite",    i, {31'd0, bus.Pwrite},    {31'd0, vecs[i].e_pw});
            chk("hrdata",    i, bus.Hrdata,             vecs[i].e_rd);
            chk("paddr",     i, bus.Paddr,              vecs[i].e_pa);
            chk("pwdata",    i, bus.Pwdata,             vecs[i].e_pwd);
            drive(vecs[i].valid, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                  vecs[i].tsel, vecs[i].prdata, vecs[i].prdy, vecs[i].perr);
            step();
        end

        // asynchronous reset during ACCESS
        drive(1'b1, 1'b0, 32'h80, Z, 3'b100, Z, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, Z, Z, 3'b000, Z, 1'b0, 1'b0);
        step();
        chk("acc_penable", 100, {31'd0, bus.Penable}, 32'd1);
        chk("acc_pselx",   100, {29'd0, bus.Pselx},   32'd4);
        Hresetn = 1'b0;
        #1;
        chk("async_pselx",     101, {29'd0, bus.Pselx},     32'd0);
        chk("async_penable",   101, {31'd0, bus.Penable},   32'd0);
        chk("async_hreadyout", 101, {31'd0, bus.Hreadyout}, 32'd1);
        step();
        chk("rst2_paddr",  102, bus.Paddr,  32'd0);
        chk("rst2_hrdata", 102, bus.Hrdata, 32'd0);
        chk("rst2_pselx",  102, {29'd0, bus.Pselx}, 32'd0);

        // new read accepted on the first edge after release; old one not retried
        Hresetn = 1'b1;
        drive(1'b1, 1'b0, 32'h84, Z, 3'b001, 32'h5A5A_5A5A, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, Z, Z, 3'b000, 32'h5A5A_5A5A, 1'b1, 1'b0);
        chk("rel_pselx",     103, {29'd0, bus.Pselx},     32'd1);
        chk("rel_paddr",     103, bus.Paddr,              32'h84);
        chk("rel_hreadyout", 103, {31'd0, bus.Hreadyout}, 32'd0);
        step();
        chk("rel_penable", 104, {31'd0, bus.Penable}, 32'd1);
        step();
        chk("rel_hrdata",    105, bus.Hrdata,             32'h5A5A_5A5A);
        chk("rel_hreadyout", 105, {31'd0, bus.Hreadyout}, 32'd1);
        chk("rel_hresp",     105, {31'd0, bus.Hresp},     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
